uart_echo_tester: RTL and testbench

Initiator end of the UART echo link. It drives the `uart` core's transmit handshake with an incrementing byte pattern, waits for each byte to come back from the far-end echo responder, and compares it. It keeps saturating pass, mismatch and timeout counts. It sits beside `uart0` in a top-level and replaces the echo logic on the board acting as link tester.

---
 rtl/uart_test_pkg.sv | 23 ++
 rtl/uart_echo_tester_cycle_timer.sv | 29 ++
 rtl/uart_echo_tester.sv | 137 +++++++++++++
 tb/tb_uart_echo_tester.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_test_pkg.sv
// Shared state encodings and counter helpers for the UART echo link tester.
package uart_test_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_ECHO = 2'd2;
  localparam logic [1:0] GAP       = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = IDLE,
    ST_SEND      = SEND,
    ST_WAIT_ECHO = WAIT_ECHO,
    ST_GAP       = GAP
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Result counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/uart_echo_tester_cycle_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module cycle_timer #(
  parameter int WIDTH      = 8,
  parameter int LOAD_VALUE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic tc
);

  localparam logic [WIDTH-1:0] LOAD_COUNT = WIDTH'(LOAD_VALUE);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_COUNT;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/uart_echo_tester.sv
// Initiator end of the UART echo link: sends an incrementing byte pattern,
// checks each echo and keeps saturating pass / error / timeout counts.
//
// state      | meaning
// IDLE       | waiting for enable and a free transmitter
// SEND       | one-cycle transmit strobe, timeout timer loaded
// WAIT_ECHO  | waiting for the echo, a framing error or the timeout
// GAP        | idle spacing before the next byte; tx_byte advances on exit
module uart_echo_tester
  import uart_test_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 60000,
  parameter int         GAP_CYCLES     = 1200,
  parameter logic [7:0] START_BYTE     = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        transmit,
  output logic [7:0]  tx_byte,
  input  logic        is_transmitting,
  input  logic        received,
  input  logic [7:0]  rx_byte,
  input  logic        recv_error,
  output logic [15:0] pass_count,
  output logic [15:0] err_count,
  output logic [15:0] timeout_count,
  output logic [7:0]  last_rx,
  output logic        busy
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t state;
  logic   timeout_tc;
  logic   gap_tc;
  logic   stray;

  assign stray = received || recv_error;

  // Loaded with TIMEOUT_CYCLES-1 in SEND, so tc lands on the last allowed WAIT_ECHO cycle.
  cycle_timer #(
    .WIDTH      (TMO_W),
    .LOAD_VALUE (TIMEOUT_CYCLES - 1)
  ) u_timeout_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == ST_SEND),
    .enable (state == ST_WAIT_ECHO),
    .tc     (timeout_tc)
  );

  cycle_timer #(
    .WIDTH      (GAP_W),
    .LOAD_VALUE (GAP_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == ST_WAIT_ECHO),
    .enable (state == ST_GAP),
    .tc     (gap_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      transmit      <= 1'b0;
      busy          <= 1'b0;
      tx_byte       <= START_BYTE;
      pass_count    <= '0;
      err_count     <= '0;
      timeout_count <= '0;
      last_rx       <= '0;
    end else begin
      transmit <= 1'b0;
      if (received) begin
        last_rx <= rx_byte;
      end

      case (state)
        ST_IDLE: begin
          if (stray) begin
            err_count <= sat_inc(err_count);
          end
          if (enable && !is_transmitting) begin
            state    <= ST_SEND;
            transmit <= 1'b1;
            busy     <= 1'b1;
          end
        end

        ST_SEND: begin
          if (stray) begin
            err_count <= sat_inc(err_count);
          end
          state <= ST_WAIT_ECHO;
        end

        ST_WAIT_ECHO: begin
          // An echo beats a timeout reached in the same cycle.
          if (received) begin
            if (rx_byte == tx_byte) begin
              pass_count <= sat_inc(pass_count);
            end else begin
              err_count <= sat_inc(err_count);
            end
            state <= ST_GAP;
          end else if (recv_error) begin
            err_count <= sat_inc(err_count);
            state     <= ST_GAP;
          end else if (timeout_tc) begin
            timeout_count <= sat_inc(timeout_count);
            state         <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (stray) begin
            err_count <= sat_inc(err_count);
          end
          if (gap_tc) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            tx_byte <= tx_byte + 8'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Self-checking bench for uart_echo_tester with a behavioural uart/echo model.
module tb_uart_echo_tester;

  localparam int TIMEOUT    = 200;
  localparam int GAP        = 10;
  localparam int ECHO_DELAY = 40;
  localparam int TX_BUSY    = 20;
  localparam int PERIOD     = 1 + ECHO_DELAY + 1 + GAP + 1;
  localparam int BUSY_SPAN  = ECHO_DELAY + 1 + GAP + 1;
  localparam int BOUND      = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        is_transmitting = 1'b0;
  logic        received;
  logic [7:0]  rx_byte;
  logic        recv_error;
  logic [15:0] pass_count, err_count, timeout_count;
  logic [7:0]  last_rx;
  logic        busy;

  logic        model_received = 1'b0;
  logic [7:0]  model_byte = 8'h00;
  logic        inj_received = 1'b0;
  logic        inj_error = 1'b0;
  logic [7:0]  inj_byte = 8'h00;

  logic        enable_fe = 1'b0;
  logic        fe_zero = 1'b0;
  logic [7:0]  fe_rx_byte = 8'h00;
  logic        fe_transmit;
  logic [7:0]  fe_tx_byte;
  logic [15:0] fe_pass, fe_err, fe_tmo;
  logic [7:0]  fe_last_rx;
  logic        fe_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int echo_mode = 0;  // 0: no echo, 1: loopback, 2: loopback with bit 0 flipped
  int tx_seen = 0;
  int fe_tx_seen = 0;
  int exp_tx_total = 0;
  int exp_pass = 0, exp_err = 0, exp_tmo = 0;
  bit period_en = 1'b0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_fe_q[$];

  assign received   = model_received | inj_received;
  assign rx_byte    = inj_received ? inj_byte : model_byte;
  assign recv_error = inj_error;

  uart_echo_tester #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .GAP_CYCLES     (GAP),
    .START_BYTE     (8'h00)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting),
    .received        (received),
    .rx_byte         (rx_byte),
    .recv_error      (recv_error),
    .pass_count      (pass_count),
    .err_count       (err_count),
    .timeout_count   (timeout_count),
    .last_rx         (last_rx),
    .busy            (busy)
  );

  uart_echo_tester #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .GAP_CYCLES     (GAP),
    .START_BYTE     (8'hFE)
  ) dut_fe (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable_fe),
    .transmit        (fe_transmit),
    .tx_byte         (fe_tx_byte),
    .is_transmitting (fe_zero),
    .received        (fe_zero),
    .rx_byte         (fe_rx_byte),
    .recv_error      (fe_zero),
    .pass_count      (fe_pass),
    .err_count       (fe_err),
    .timeout_count   (fe_tmo),
    .last_rx         (fe_last_rx),
    .busy            (fe_busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Far-end model: is_transmitting for TX_BUSY cycles, echo ECHO_DELAY cycles after the strobe.
  initial begin : uart_model
    int busy_left = 0;
    int echo_left = 0;
    logic [7:0] echo_val = 8'h00;
    forever begin
      @(negedge clk);
      model_received = 1'b0;
      if (busy_left > 0) busy_left--;
      if (echo_left > 0) begin
        echo_left--;
        if (echo_left == 0) begin
          model_received = 1'b1;
          model_byte     = echo_val;
        end
      end
      if (transmit && !rst) begin
        busy_left = TX_BUSY;
        if (echo_mode != 0) begin
          echo_left = ECHO_DELAY;
          echo_val  = (echo_mode == 2) ? (tx_byte ^ 8'h01) : tx_byte;
        end
      end
      is_transmitting = (busy_left > 0);
    end
  end

  initial begin : tx_monitor
    int prev_cyc = 0;
    bit have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!period_en) have_prev = 1'b0;
      if (!rst && transmit) begin
        tx_seen++;
        if (exp_tx_q.size() > 0) check_val("tx_byte", 32'(tx_byte), 32'(exp_tx_q.pop_front()));
        if (period_en && have_prev) check_val("period", 32'(cyc - prev_cyc), PERIOD);
        prev_cyc  = cyc;
        have_prev = 1'b1;
      end
    end
  end

  initial begin : fe_monitor
    forever begin
      @(negedge clk);
      if (!rst && fe_transmit) begin
        fe_tx_seen++;
        if (exp_fe_q.size() > 0) check_val("fe_tx_byte", 32'(fe_tx_byte), 32'(exp_fe_q.pop_front()));
      end
    end
  end

  task automatic wait_tx(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!transmit && n < BOUND);
    check_val(tag, 32'(transmit), 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < BOUND);
    check_val(tag, 32'(busy), 0);
  endtask

  task automatic wait_model_rx(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!model_received && n < BOUND);
    check_val(tag, 32'(model_received), 1);
  endtask

  task automatic check_counts(input string tag);
    check_val({tag, "_pass"}, 32'(pass_count), exp_pass);
    check_val({tag, "_err"}, 32'(err_count), exp_err);
    check_val({tag, "_tmo"}, 32'(timeout_count), exp_tmo);
  endtask

  initial begin : main
    int t0;
    int n;
    repeat (3) @(negedge clk);
    check_val("rst_transmit", 32'(transmit), 0);
    check_val("rst_tx_byte", 32'(tx_byte), 'h00);
    check_val("rst_last_rx", 32'(last_rx), 'h00);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_fe_tx_byte", 32'(fe_tx_byte), 'hFE);
    check_counts("rst");
    rst = 1'b0;

    // Plain loopback, four exchanges back to back, enable dropped mid-exchange.
    echo_mode = 1;
    period_en = 1'b1;
    for (int i = 0; i < 4; i++) exp_tx_q.push_back(8'(i));
    enable = 1'b1;
    for (int i = 0; i < 4; i++) wait_tx("p1_tx");
    enable = 1'b0;
    wait_idle("p1_idle");
    period_en = 1'b0;
    exp_pass += 4;
    exp_tx_total += 4;
    repeat (100) @(negedge clk);
    check_val("p1_stays_idle", 32'(busy), 0);
    check_val("p1_tx_count", 32'(tx_seen), exp_tx_total);
    check_counts("p1");
    check_val("p1_last_rx", 32'(last_rx), 'h03);
    check_val("p1_tx_next", 32'(tx_byte), 'h04);

    // Stray byte during GAP.
    exp_tx_q.push_back(8'h04);
    enable = 1'b1;
    wait_tx("p2_tx");
    t0 = cyc;
    enable = 1'b0;
    wait_model_rx("p2_echo");
    repeat (3) @(negedge clk);
    inj_byte     = 8'hAA;
    inj_received = 1'b1;
    @(negedge clk);
    inj_received = 1'b0;
    wait_idle("p2_idle");
    check_val("p2_busy_span", 32'(cyc - t0), BUSY_SPAN);
    exp_pass++;
    exp_err++;
    exp_tx_total++;
    check_counts("p2");
    check_val("p2_last_rx", 32'(last_rx), 'hAA);
    check_val("p2_tx_next", 32'(tx_byte), 'h05);

    // Corrupted echo.
    echo_mode = 2;
    exp_tx_q.push_back(8'h05);
    exp_tx_q.push_back(8'h06);
    enable = 1'b1;
    wait_tx("p3_tx");
    wait_tx("p3_tx");
    enable = 1'b0;
    wait_idle("p3_idle");
    exp_err += 2;
    exp_tx_total += 2;
    check_counts("p3");
    check_val("p3_last_rx", 32'(last_rx), 'h07);
    check_val("p3_tx_next", 32'(tx_byte), 'h07);

    // Echo suppressed: exact timeout edge, then an echo on the final allowed cycle.
    echo_mode = 0;
    exp_tx_q.push_back(8'h07);
    exp_tx_q.push_back(8'h08);
    enable = 1'b1;
    wait_tx("p4_tx");
    repeat (TIMEOUT) @(posedge clk);
    @(negedge clk);
    check_val("p4_tmo_early", 32'(timeout_count), exp_tmo);
    @(posedge clk);
    @(negedge clk);
    exp_tmo++;
    check_val("p4_tmo_at_limit", 32'(timeout_count), exp_tmo);
    wait_tx("p4_tx2");
    enable = 1'b0;
    repeat (TIMEOUT) @(posedge clk);
    @(negedge clk);
    inj_byte     = 8'h08;
    inj_received = 1'b1;
    @(posedge clk);
    @(negedge clk);
    inj_received = 1'b0;
    exp_pass++;
    check_counts("p4_late_echo");
    wait_idle("p4_idle");
    exp_tx_total += 2;
    check_counts("p4");
    check_val("p4_tx_next", 32'(tx_byte), 'h09);

    // Framing error while waiting.
    exp_tx_q.push_back(8'h09);
    enable = 1'b1;
    wait_tx("p4b_tx");
    enable = 1'b0;
    repeat (5) @(negedge clk);
    inj_error = 1'b1;
    @(negedge clk);
    inj_error = 1'b0;
    wait_idle("p4b_idle");
    exp_err++;
    exp_tx_total++;
    check_counts("p4b");
    check_val("p4b_tx_next", 32'(tx_byte), 'h0A);

    // Asynchronous reset in WAIT_ECHO, then the late echo arrives as a stray.
    echo_mode = 1;
    exp_tx_q.push_back(8'h0A);
    enable = 1'b1;
    wait_tx("p5_tx");
    enable = 1'b0;
    exp_tx_total++;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_pass = 0;
    exp_err  = 0;
    exp_tmo  = 0;
    check_counts("p5_async");
    check_val("p5_async_busy", 32'(busy), 0);
    check_val("p5_async_tx_byte", 32'(tx_byte), 'h00);
    check_val("p5_async_last_rx", 32'(last_rx), 'h00);
    @(negedge clk);
    rst = 1'b0;
    wait_model_rx("p5_late");
    repeat (2) @(negedge clk);
    exp_err = 1;
    check_counts("p5_late");
    check_val("p5_last_rx", 32'(last_rx), 'h0A);
    check_val("p5_busy", 32'(busy), 0);
    check_val("p5_tx_byte", 32'(tx_byte), 'h00);

    // START_BYTE=FE instance: wrap FE, FF, 00 through timeouts.
    exp_fe_q.push_back(8'hFE);
    exp_fe_q.push_back(8'hFF);
    exp_fe_q.push_back(8'h00);
    enable_fe = 1'b1;
    n = 0;
    while (fe_tx_seen < 3 && n < 4 * BOUND) begin
      @(negedge clk);
      n++;
    end
    check_val("fe_tx_seen", 32'(fe_tx_seen), 3);
    enable_fe = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fe_busy && n < BOUND);
    check_val("fe_idle", 32'(fe_busy), 0);
    check_val("fe_tx_next", 32'(fe_tx_byte), 'h01);
    check_val("fe_tmo", 32'(fe_tmo), 3);
    check_val("fe_err", 32'(fe_err), 0);
    check_val("fe_pass", 32'(fe_pass), 0);
    check_val("fe_last_rx", 32'(fe_last_rx), 0);

    check_val("tx_total", 32'(tx_seen), exp_tx_total);
    check_val("tx_queue_left", 32'(exp_tx_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
